// File: rtl/fft_ram_reader.sv
// Streams an N-point FFT result out of four interleaved RAM banks, in natural or bit-reversed
// order, through a two-entry output buffer so that iREADY back-pressure never drops a sample.
module fft_ram_reader #(
    parameter int D_BIT = 17,
    parameter int A_BIT = 10
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iSTART,
    input  logic             iBIT_REV,
    output logic [A_BIT-1:0] oADDR_RD_0,
    output logic [A_BIT-1:0] oADDR_RD_1,
    output logic [A_BIT-1:0] oADDR_RD_2,
    output logic [A_BIT-1:0] oADDR_RD_3,
    input  logic [D_BIT-1:0] iDATA_RE_0,
    input  logic [D_BIT-1:0] iDATA_RE_1,
    input  logic [D_BIT-1:0] iDATA_RE_2,
    input  logic [D_BIT-1:0] iDATA_RE_3,
    input  logic [D_BIT-1:0] iDATA_IM_0,
    input  logic [D_BIT-1:0] iDATA_IM_1,
    input  logic [D_BIT-1:0] iDATA_IM_2,
    input  logic [D_BIT-1:0] iDATA_IM_3,
    output logic [D_BIT-1:0] oDATA_RE,
    output logic [D_BIT-1:0] oDATA_IM,
    output logic [A_BIT+1:0] oINDEX,
    output logic             oVALID,
    input  logic             iREADY,
    output logic             oBUSY,
    output logic             oDONE
);
    localparam int K_BIT = A_BIT + 2;
    localparam logic [K_BIT-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, stateNext;

    logic [K_BIT-1:0] rdIdx;
    logic [K_BIT-1:0] rdLoc;
    logic             bitRev;
    logic             issue;
    logic             transfer;
    logic             lastXfer;
    logic [1:0]       occAfter;

    logic             flightValid;
    logic [1:0]       flightBank;
    logic [K_BIT-1:0] flightIdx;
    logic [D_BIT-1:0] inRe, inIm;

    logic             outValid, skidValid;
    logic [D_BIT-1:0] outRe, outIm, skidRe, skidIm;
    logic [K_BIT-1:0] outIdx, skidIdx;
    logic             done;

    function automatic logic [K_BIT-1:0] bitReverse(input logic [K_BIT-1:0] x);
        logic [K_BIT-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < K_BIT; i++) begin
            r[i] = x[K_BIT-1-i];
        end
        return r;
    endfunction

    assign rdLoc      = bitRev ? bitReverse(rdIdx) : rdIdx;
    assign oADDR_RD_0 = rdLoc[K_BIT-1:2];
    assign oADDR_RD_1 = rdLoc[K_BIT-1:2];
    assign oADDR_RD_2 = rdLoc[K_BIT-1:2];
    assign oADDR_RD_3 = rdLoc[K_BIT-1:2];

    assign transfer = outValid & iREADY;
    assign lastXfer = transfer && (outIdx == LAST_IDX);
    // Entries still held after this edge: buffered + in flight, minus what the sink takes now.
    assign occAfter = 2'(outValid) + 2'(skidValid) + 2'(flightValid) - 2'(transfer);

    always_comb begin
        stateNext = state;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (iSTART) stateNext = RUN;
            end
            RUN: begin
                if (occAfter < 2'd2) begin
                    issue = 1'b1;
                    if (rdIdx == LAST_IDX) stateNext = DRAIN;
                end
            end
            DRAIN: begin
                if (lastXfer) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) state <= IDLE;
        else        state <= stateNext;
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            rdIdx       <= '0;
            bitRev      <= 1'b0;
            flightValid <= 1'b0;
            flightBank  <= '0;
            flightIdx   <= '0;
            done        <= 1'b0;
        end else begin
            if (state == IDLE && iSTART) begin
                rdIdx  <= '0;
                bitRev <= iBIT_REV;
            end else if (issue && rdIdx != LAST_IDX) begin
                rdIdx <= rdIdx + K_BIT'(1);
            end
            flightValid <= issue;
            flightBank  <= rdLoc[1:0];
            flightIdx   <= rdIdx;
            done        <= (state == DRAIN) && lastXfer;
        end
    end

    always_comb begin
        inRe = iDATA_RE_0;
        inIm = iDATA_IM_0;
        case (flightBank)
            2'd1: begin inRe = iDATA_RE_1; inIm = iDATA_IM_1; end
            2'd2: begin inRe = iDATA_RE_2; inIm = iDATA_IM_2; end
            2'd3: begin inRe = iDATA_RE_3; inIm = iDATA_IM_3; end
            default: ;
        endcase
    end

    // Output register refills from the skid entry first, so ordering is kept under stalls.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            outValid  <= 1'b0;
            outRe     <= '0;
            outIm     <= '0;
            outIdx    <= '0;
            skidValid <= 1'b0;
            skidRe    <= '0;
            skidIm    <= '0;
            skidIdx   <= '0;
        end else if (!outValid || transfer) begin
            if (skidValid) begin
                outValid  <= 1'b1;
                outRe     <= skidRe;
                outIm     <= skidIm;
                outIdx    <= skidIdx;
                skidValid <= flightValid;
                if (flightValid) begin
                    skidRe  <= inRe;
                    skidIm  <= inIm;
                    skidIdx <= flightIdx;
                end
            end else begin
                outValid <= flightValid;
                if (flightValid) begin
                    outRe  <= inRe;
                    outIm  <= inIm;
                    outIdx <= flightIdx;
                end
            end
        end else if (flightValid) begin
            skidValid <= 1'b1;
            skidRe    <= inRe;
            skidIm    <= inIm;
            skidIdx   <= flightIdx;
        end
    end

    assign oDATA_RE = outRe;
    assign oDATA_IM = outIm;
    assign oINDEX   = outIdx;
    assign oVALID   = outValid;
    assign oBUSY    = (state != IDLE);
    assign oDONE    = done;
endmodule

// File: tb/tb_fft_ram_reader.sv
// Bench for fft_ram_reader (A_BIT=2, N=16) with a modelled 1-cycle-latency RAM and an
// order/data reference computed from the index mapping rules.
module tb_fft_ram_reader;
    localparam int D_BIT = 17;
    localparam int A_BIT = 2;
    localparam int N     = 16;

    logic             iCLK = 1'b0;
    logic             iRESET = 1'b1;
    logic             iSTART = 1'b0;
    logic             iBIT_REV = 1'b0;
    logic             iREADY = 1'b1;
    logic [A_BIT-1:0] oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3;
    logic [D_BIT-1:0] dRe0, dRe1, dRe2, dRe3, dIm0, dIm1, dIm2, dIm3;
    logic [D_BIT-1:0] oDATA_RE, oDATA_IM;
    logic [A_BIT+1:0] oINDEX;
    logic             oVALID, oBUSY, oDONE;

    int errors = 0;
    int checks = 0;

    int               recIdx[$];
    logic [D_BIT-1:0] recRe[$];
    logic [D_BIT-1:0] recIm[$];
    int               recCyc[$];
    int               firstValid, doneAt, doneCount, unstable;
    logic             timedOut, busyAtStart, busyAtDone;

    always #5 iCLK = ~iCLK;

    fft_ram_reader #(.D_BIT(D_BIT), .A_BIT(A_BIT)) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iSTART(iSTART), .iBIT_REV(iBIT_REV),
        .oADDR_RD_0(oADDR_RD_0), .oADDR_RD_1(oADDR_RD_1),
        .oADDR_RD_2(oADDR_RD_2), .oADDR_RD_3(oADDR_RD_3),
        .iDATA_RE_0(dRe0), .iDATA_RE_1(dRe1), .iDATA_RE_2(dRe2), .iDATA_RE_3(dRe3),
        .iDATA_IM_0(dIm0), .iDATA_IM_1(dIm1), .iDATA_IM_2(dIm2), .iDATA_IM_3(dIm3),
        .oDATA_RE(oDATA_RE), .oDATA_IM(oDATA_IM), .oINDEX(oINDEX),
        .oVALID(oVALID), .iREADY(iREADY), .oBUSY(oBUSY), .oDONE(oDONE)
    );

    // Bank b, address a holds RE = 16*b + a, IM = -(16*b + a); data one cycle after address.
    always @(posedge iCLK) begin
        dRe0 <= D_BIT'(0  + int'(oADDR_RD_0));
        dRe1 <= D_BIT'(16 + int'(oADDR_RD_1));
        dRe2 <= D_BIT'(32 + int'(oADDR_RD_2));
        dRe3 <= D_BIT'(48 + int'(oADDR_RD_3));
        dIm0 <= D_BIT'(-(0  + int'(oADDR_RD_0)));
        dIm1 <= D_BIT'(-(16 + int'(oADDR_RD_1)));
        dIm2 <= D_BIT'(-(32 + int'(oADDR_RD_2)));
        dIm3 <= D_BIT'(-(48 + int'(oADDR_RD_3)));
    end

    function automatic int expLoc(input int k, input bit br);
        int r, x;
        if (!br) return k;
        r = 0;
        x = k;
        for (int i = 0; i < A_BIT + 2; i++) begin
            r = r * 2 + x % 2;
            x = x / 2;
        end
        return r;
    endfunction

    function automatic int expRe(input int k, input bit br);
        int m;
        m = expLoc(k, br);
        return 16 * (m % 4) + m / 4;
    endfunction

    // Drives one unload and records every transfer; mode 0 = ready high, 1 = random, 2 = stall.
    task automatic runUnload(input bit br, input int mode, input bit chained, input bit chainOut,
                             input int pulseAt);
        bit               prevStall;
        logic [D_BIT-1:0] pRe, pIm;
        logic [A_BIT+1:0] pIdx;
        int               stopAt;
        prevStall = 0; pRe = '0; pIm = '0; pIdx = '0; stopAt = -1;
        recIdx.delete(); recRe.delete(); recIm.delete(); recCyc.delete();
        firstValid = -1; doneAt = -1; doneCount = 0; unstable = 0; timedOut = 1'b1;
        busyAtStart = 1'b0; busyAtDone = 1'b1;
        if (!chained) begin
            @(negedge iCLK);
            iBIT_REV = br;
            iSTART   = 1'b1;
        end
        @(posedge iCLK);
        for (int e = 0; e < 400; e++) begin
            @(negedge iCLK);
            iSTART = (e == pulseAt);
            if (e == 3) iBIT_REV = ~br;
            if (e == 0) busyAtStart = oBUSY;
            case (mode)
                0:       iREADY = 1'b1;
                1:       iREADY = 1'($urandom_range(0, 1));
                default: iREADY = !(e >= 2 && e < 12);
            endcase
            if (prevStall && (oVALID !== 1'b1 || oINDEX !== pIdx || oDATA_RE !== pRe || oDATA_IM !== pIm))
                unstable++;
            if (oVALID === 1'b1 && firstValid < 0) firstValid = e;
            if (oVALID === 1'b1 && iREADY === 1'b1) begin
                recIdx.push_back(int'(oINDEX));
                recRe.push_back(oDATA_RE);
                recIm.push_back(oDATA_IM);
                recCyc.push_back(e);
            end
            prevStall = (oVALID === 1'b1 && iREADY === 1'b0);
            pRe = oDATA_RE; pIm = oDATA_IM; pIdx = oINDEX;
            if (oDONE === 1'b1) begin
                doneCount++;
                if (doneAt < 0) begin
                    doneAt = e; busyAtDone = oBUSY; timedOut = 1'b0; stopAt = e + 3;
                end
                if (chainOut) begin
                    iBIT_REV = br;
                    iSTART   = 1'b1;
                    break;
                end
            end
            if (e == stopAt) break;
        end
        if (!chainOut) iSTART = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge iCLK);
        iRESET = 1'b1; iSTART = 1'b1; iREADY = 1'b1;
        repeat (3) @(posedge iCLK);
        @(negedge iCLK);
        checks++; if (oBUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", oBUSY); end
        checks++; if (oVALID !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", oVALID); end
        checks++; if (oDONE !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", oDONE); end
        checks++; if (oINDEX !== '0) begin errors++; $display("FAIL reset_index got=%0d want=0", oINDEX); end
        checks++; if (oDATA_RE !== '0 || oDATA_IM !== '0) begin
            errors++; $display("FAIL reset_data got=%h/%h want=0/0", oDATA_RE, oDATA_IM); end
        checks++; if ({oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3} !== '0) begin
            errors++; $display("FAIL reset_addr got=%h want=0", {oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3}); end
        iRESET = 1'b0; iSTART = 1'b0;
        @(negedge iCLK);
        checks++; if (oBUSY !== 1'b0) begin errors++; $display("FAIL reset_start_priority busy=%b want=0", oBUSY); end
    endtask

    task automatic test_natural;
        runUnload(1'b0, 0, 1'b0, 1'b0, -1);
        checks++; if (timedOut !== 1'b0) begin errors++; $display("FAIL nat_timeout got=%b want=0", timedOut); end
        checks++; if (recIdx.size() != N) begin errors++; $display("FAIL nat_count got=%0d want=%0d", recIdx.size(), N); end
        for (int i = 0; i < recIdx.size(); i++) begin
            checks++;
            if (recIdx[i] != i || recRe[i] !== D_BIT'(expRe(i, 1'b0)) || recIm[i] !== D_BIT'(-expRe(i, 1'b0))) begin
                errors++;
                $display("FAIL nat_sample[%0d] got k=%0d re=%0d im=%h want k=%0d re=%0d", i, recIdx[i],
                         recRe[i], recIm[i], i, expRe(i, 1'b0));
            end
        end
        checks++; if (firstValid != 2) begin errors++; $display("FAIL nat_first_valid got=%0d want=2", firstValid); end
        checks++; if (doneAt != 18) begin errors++; $display("FAIL nat_done_cycle got=%0d want=18", doneAt); end
        checks++; if (busyAtStart !== 1'b1 || busyAtDone !== 1'b0) begin
            errors++; $display("FAIL nat_busy got=%b/%b want=1/0", busyAtStart, busyAtDone); end
        checks++; if (doneCount != 1) begin errors++; $display("FAIL nat_done_once got=%0d want=1", doneCount); end
    endtask

    task automatic test_bitrev;
        runUnload(1'b1, 0, 1'b0, 1'b0, -1);
        checks++; if (recIdx.size() != N) begin errors++; $display("FAIL rev_count got=%0d want=%0d", recIdx.size(), N); end
        for (int i = 0; i < recIdx.size(); i++) begin
            checks++;
            if (recIdx[i] != i || recRe[i] !== D_BIT'(expRe(i, 1'b1)) || recIm[i] !== D_BIT'(-expRe(i, 1'b1))) begin
                errors++;
                $display("FAIL rev_sample[%0d] got k=%0d re=%0d want k=%0d re=%0d", i, recIdx[i], recRe[i],
                         i, expRe(i, 1'b1));
            end
        end
        checks++; if (doneAt != 18) begin errors++; $display("FAIL rev_done_cycle got=%0d want=18", doneAt); end
    endtask

    task automatic test_random_ready;
        for (int r = 0; r < 3; r++) begin
            bit br;
            br = 1'($urandom_range(0, 1));
            runUnload(br, 1, 1'b0, 1'b0, -1);
            checks++; if (timedOut !== 1'b0 || recIdx.size() != N) begin
                errors++; $display("FAIL rnd_count[%0d] got=%0d timeout=%b want=%0d", r, recIdx.size(), timedOut, N); end
            for (int i = 0; i < recIdx.size(); i++) begin
                checks++;
                if (recIdx[i] != i || recRe[i] !== D_BIT'(expRe(i, br)) || recIm[i] !== D_BIT'(-expRe(i, br))) begin
                    errors++;
                    $display("FAIL rnd_sample[%0d] got k=%0d re=%0d want k=%0d re=%0d", i, recIdx[i], recRe[i],
                             i, expRe(i, br));
                end
            end
            checks++; if (unstable != 0) begin errors++; $display("FAIL rnd_stable got=%0d want=0", unstable); end
            checks++; if (doneCount != 1) begin errors++; $display("FAIL rnd_done_once got=%0d want=1", doneCount); end
        end
    endtask

    task automatic test_stall;
        runUnload(1'b0, 2, 1'b0, 1'b0, -1);
        checks++; if (recIdx.size() != N) begin errors++; $display("FAIL stall_count got=%0d want=%0d", recIdx.size(), N); end
        checks++; if (unstable != 0) begin errors++; $display("FAIL stall_hold got=%0d want=0", unstable); end
        if (recIdx.size() == N) begin
            checks++; if (recCyc[0] != 12) begin errors++; $display("FAIL stall_first_xfer got=%0d want=12", recCyc[0]); end
            for (int i = 1; i < N; i++) begin
                checks++;
                if (recIdx[i] != i || recCyc[i] != recCyc[i-1] + 1 || recRe[i] !== D_BIT'(expRe(i, 1'b0))) begin
                    errors++;
                    $display("FAIL stall_stream[%0d] got k=%0d cyc=%0d re=%0d want k=%0d cyc=%0d re=%0d", i,
                             recIdx[i], recCyc[i], recRe[i], i, recCyc[i-1] + 1, expRe(i, 1'b0));
                end
            end
        end
        checks++; if (doneAt != 28) begin errors++; $display("FAIL stall_done_cycle got=%0d want=28", doneAt); end
    endtask

    task automatic test_reset_midrun;
        bit found;
        found = 0;
        @(negedge iCLK);
        iBIT_REV = 1'b0; iSTART = 1'b1; iREADY = 1'b1;
        @(posedge iCLK);
        for (int e = 0; e < 100; e++) begin
            @(negedge iCLK);
            iSTART = 1'b0;
            if (oVALID === 1'b1 && oINDEX == 7) begin found = 1; break; end
        end
        checks++; if (!found) begin errors++; $display("FAIL midrun_reach_k7 got=0 want=1"); end
        iRESET = 1'b1;
        @(negedge iCLK);
        checks++;
        if (oVALID !== 1'b0 || oBUSY !== 1'b0 || oDONE !== 1'b0 || oINDEX !== '0 || oDATA_RE !== '0 ||
            oDATA_IM !== '0 || {oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3} !== '0) begin
            errors++;
            $display("FAIL midrun_reset got v=%b b=%b d=%b k=%0d re=%h im=%h want all 0", oVALID, oBUSY,
                     oDONE, oINDEX, oDATA_RE, oDATA_IM);
        end
        iRESET = 1'b0;
        runUnload(1'b0, 0, 1'b0, 1'b0, -1);
        checks++; if (recIdx.size() != N || recIdx[0] != 0 || recRe[0] !== D_BIT'(expRe(0, 1'b0))) begin
            errors++; $display("FAIL midrun_restart got n=%0d want n=%0d from k=0", recIdx.size(), N); end
        checks++; if (firstValid != 2 || doneAt != 18) begin
            errors++; $display("FAIL midrun_restart_timing got=%0d/%0d want=2/18", firstValid, doneAt); end
    endtask

    task automatic test_back_to_back;
        runUnload(1'b1, 0, 1'b0, 1'b1, 5);
        checks++; if (recIdx.size() != N || doneAt != 18) begin
            errors++; $display("FAIL b2b_first got n=%0d done=%0d want n=%0d done=18", recIdx.size(), doneAt, N); end
        for (int i = 0; i < recIdx.size(); i++) begin
            checks++;
            if (recIdx[i] != i || recRe[i] !== D_BIT'(expRe(i, 1'b1))) begin
                errors++; $display("FAIL b2b_first_sample[%0d] got k=%0d re=%0d want re=%0d", i, recIdx[i],
                                   recRe[i], expRe(i, 1'b1));
            end
        end
        runUnload(1'b1, 0, 1'b1, 1'b0, -1);
        checks++; if (busyAtStart !== 1'b1 || firstValid != 2 || doneAt != 18) begin
            errors++; $display("FAIL b2b_second_timing got busy=%b first=%0d done=%0d want 1/2/18",
                               busyAtStart, firstValid, doneAt); end
        checks++; if (recIdx.size() != N) begin errors++; $display("FAIL b2b_second_count got=%0d want=%0d", recIdx.size(), N); end
        for (int i = 0; i < recIdx.size(); i++) begin
            checks++;
            if (recIdx[i] != i || recRe[i] !== D_BIT'(expRe(i, 1'b1)) || recIm[i] !== D_BIT'(-expRe(i, 1'b1))) begin
                errors++; $display("FAIL b2b_second_sample[%0d] got k=%0d re=%0d want re=%0d", i, recIdx[i],
                                   recRe[i], expRe(i, 1'b1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_natural();
        test_bitrev();
        test_random_ready();
        test_stall();
        test_reset_midrun();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
